// File: rtl/al_pad_ctrl_pkg.sv
// Shared encodings for the half-duplex pad controller: FSM states and
// arbiter grant identifiers.
package al_pad_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    TURN   = 2'd3
  } state_e;

  // Identity of the requester that last won arbitration
  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

endpackage

// File: rtl/al_pad_rr_arb2.sv
// Two-requester round-robin arbiter (write side vs read side).
// Grants are combinational and only offered while en is high; the
// requesters hold their request until granted, so a grant is a handshake
// and last_grant is updated on every grant.
module al_pad_rr_arb2
  import al_pad_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  gnt_e last_grant_q;
  gnt_e last_grant_d;

  // Grant decision: a lone requester wins, a contest goes to the side
  // that did not win last time
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (en) begin
      if (req_wr && (!req_rd || (last_grant_q == GNT_RD))) begin
        gnt_wr = 1'b1;
      end else if (req_rd) begin
        gnt_rd = 1'b1;
      end
    end
  end

  // Remember the winner of every grant
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_wr) begin
      last_grant_d = GNT_WR;
    end else if (gnt_rd) begin
      last_grant_d = GNT_RD;
    end
  end

  // last_grant register; reset to READ so the first contest goes to write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_RD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/al_pad_bidir_ctrl.sv
// Half-duplex controller sharing one bidirectional pad between a write
// requester and a read requester. Words move MSB-first, one bit per
// BIT_DIV clocks, followed by a tri-stated turnaround of TURN_CYC cycles.
// All outputs except wr_ready/rd_ack come straight from flops, computed
// from the next-state values so they change together with the state.
module al_pad_bidir_ctrl
  import al_pad_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BIT_DIV  = 4,
  parameter int TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              pad_otrue,
  output logic              pad_ts,
  input  logic              pad_di
);

  localparam int DIV_W  = $clog2(BIT_DIV);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam int TURN_W = $clog2(TURN_CYC + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_MID   = DIV_W'(BIT_DIV / 2);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);
  localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);

  state_e              state_q,     state_d;
  logic [DIV_W-1:0]    div_cnt_q,   div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [TURN_W-1:0]   turn_cnt_q,  turn_cnt_d;
  logic [DATA_W-1:0]   tx_shift_q,  tx_shift_d;
  logic [DATA_W-1:0]   rx_shift_q,  rx_shift_d;
  logic [DATA_W-1:0]   rd_data_q,   rd_data_d;
  logic                rd_valid_q,  rd_valid_d;
  logic                busy_q,      busy_d;
  logic                pad_ts_q,    pad_ts_d;
  logic                pad_otrue_q, pad_otrue_d;

  logic arb_en;
  logic gnt_wr;
  logic gnt_rd;
  logic div_wrap;
  logic last_bit;

  // Arbitration is only meaningful while the pin is free
  assign arb_en = (state_q == IDLE);

  al_pad_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (arb_en),
    .req_wr (wr_valid),
    .req_rd (rd_req),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  assign wr_ready = gnt_wr;
  assign rd_ack   = gnt_rd;

  assign div_wrap = (div_cnt_q == DIV_LAST);
  assign last_bit = (bit_cnt_q == '0);

  // State register plus all datapath and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      turn_cnt_q  <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      pad_ts_q    <= 1'b1;
      pad_otrue_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      pad_ts_q    <= pad_ts_d;
      pad_otrue_q <= pad_otrue_d;
    end
  end

  // Next-state logic: handshake leaves IDLE, last bit wrap enters TURN,
  // turnaround expiry returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_wr) begin
          state_d = DRIVE;
        end else if (gnt_rd) begin
          state_d = SAMPLE;
        end
      end
      DRIVE, SAMPLE: begin
        if (div_wrap && last_bit) begin
          state_d = TURN;
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and shift registers; the receive register samples mid-bit
  // and is copied to rd_data at the last bit's divider wrap
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    turn_cnt_d = turn_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        div_cnt_d  = '0;
        bit_cnt_d  = BIT_LAST;
        turn_cnt_d = '0;
        if (gnt_wr) begin
          tx_shift_d = wr_data;
        end
        if (gnt_rd) begin
          rx_shift_d = '0;
        end
      end
      DRIVE: begin
        if (div_wrap) begin
          div_cnt_d  = '0;
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q - BIT_ONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
      end
      SAMPLE: begin
        if (div_cnt_q == DIV_MID) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], pad_di};
        end
        if (div_wrap) begin
          div_cnt_d = '0;
          if (last_bit) begin
            rd_data_d = rx_shift_d;
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_ONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          turn_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_ONE;
        end
      end
      default: begin
        div_cnt_d = '0;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state: the pin is only
  // driven while the controller will be in DRIVE
  always_comb begin
    pad_ts_d    = (state_d != DRIVE);
    pad_otrue_d = (state_d == DRIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
    rd_valid_d  = (state_q == SAMPLE) && (state_d == TURN);
    busy_d      = (state_d != IDLE);
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign pad_ts    = pad_ts_q;
  assign pad_otrue = pad_otrue_q;

endmodule

// File: tb/tb_al_pad_bidir_ctrl.sv
// Self-checking bench for al_pad_bidir_ctrl. A transaction-level model
// (handshake cycle, word, fixed transfer length) predicts every output;
// handshakes push expected transfers into a scoreboard that a separate
// monitor drains when the pin finishes driving or rd_valid pulses.
module tb_al_pad_bidir_ctrl;

  localparam int DW    = 8;
  localparam int BD    = 4;
  localparam int TC    = 2;
  localparam int XFER  = DW * BD;        // pin cycles per word
  localparam int SLOT  = XFER + TC + 1;  // handshake-to-handshake spacing

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic          pad_di = 1'b0;
  logic          wr_ready, rd_ack, rd_valid, busy, pad_otrue, pad_ts;
  logic [DW-1:0] rd_data;

  al_pad_bidir_ctrl #(.DATA_W(DW), .BIT_DIV(BD), .TURN_CYC(TC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .pad_otrue (pad_otrue),
    .pad_ts    (pad_ts),
    .pad_di    (pad_di)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_wr;
    logic [DW-1:0] data;
    int          hs;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Transaction-level reference model (written only by the stimulus)
  int            m_kind = 0;      // 0 none, 1 write, 2 read
  int            m_hs = 0;
  int            m_free = 0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_rdata_prev = '0;
  bit            m_last_rd = 1'b1;
  bit            m_gnt_wr = 1'b0;
  bit            m_gnt_rd = 1'b0;
  bit            in_reset = 1'b1;
  bit            acc_wr = 1'b0;
  bit            acc_rd = 1'b0;
  logic [DW-1:0] rd_pin_word = '0;

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Pin stimulus for a read: the correct bit only at mid-bit, noise elsewhere
  task automatic drive_pin();
    int off;
    pad_di = 1'($urandom);
    if (m_kind == 2 && cyc >= m_hs + 1 && cyc <= m_hs + XFER) begin
      off = cyc - m_hs - 1;
      if (off % BD == BD / 2) pad_di = m_data[DW - 1 - off / BD];
    end
  endtask

  // Round-robin decision for the current cycle; records handshakes
  task automatic arbitrate();
    txn_t t;
    m_gnt_wr = 1'b0;
    m_gnt_rd = 1'b0;
    if (!in_reset && cyc >= m_free) begin
      if (wr_valid && (!rd_req || m_last_rd)) m_gnt_wr = 1'b1;
      else if (rd_req) m_gnt_rd = 1'b1;
    end
    if (m_gnt_wr || m_gnt_rd) begin
      if (m_kind == 2) m_rdata_prev = m_data;
      m_kind    = m_gnt_wr ? 1 : 2;
      m_hs      = cyc;
      m_data    = m_gnt_wr ? wr_data : rd_pin_word;
      m_free    = cyc + SLOT;
      m_last_rd = m_gnt_rd;
      t.is_wr = m_gnt_wr;
      t.data  = m_data;
      t.hs    = cyc;
      sb.push_back(t);
      acc_wr = m_gnt_wr;
      acc_rd = m_gnt_rd;
    end
  endtask

  task automatic run_cycle(input bit want_wr, input logic [DW-1:0] wd,
                           input bit want_rd, input logic [DW-1:0] rdd,
                           input bit allow_drop);
    @(posedge clk);
    #1;
    if (acc_wr) begin wr_valid = 1'b0; acc_wr = 1'b0; end
    if (acc_rd) begin rd_req = 1'b0; acc_rd = 1'b0; end
    if (allow_drop && wr_valid && $urandom_range(0, 39) == 0) wr_valid = 1'b0;
    if (allow_drop && rd_req && $urandom_range(0, 39) == 0) rd_req = 1'b0;
    if (want_wr && !wr_valid) begin wr_valid = 1'b1; wr_data = wd; end
    if (want_rd && !rd_req) begin rd_req = 1'b1; rd_pin_word = rdd; end
    drive_pin();
    arbitrate();
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic issue(input bit w, input bit r, input logic [DW-1:0] d);
    int n = 0;
    do begin
      run_cycle(w, d, r, d, 1'b0);
      n++;
    end while (!(acc_wr || acc_rd) && n < 200);
    check_eq("handshake_in_budget", int'(acc_wr || acc_rd), 1);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wr_valid = 1'b0; rd_req = 1'b0;
    acc_wr = 1'b0; acc_rd = 1'b0;
    in_reset = 1'b1;
    m_kind = 0; m_rdata_prev = '0; m_last_rd = 1'b1;
    m_gnt_wr = 1'b0; m_gnt_rd = 1'b0;
    sb.delete();
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    m_free = cyc;
  endtask

  // Monitor: per-cycle output checks plus scoreboard drain
  initial begin : monitor
    int            run_len;
    int            run_start;
    logic [DW-1:0] word;
    bit            act_tx;
    int            exp_ot;
    int            exp_rdata;
    txn_t          t;
    run_len = 0; run_start = 0; word = '0;
    forever begin
      @(negedge clk);
      act_tx = !in_reset && m_kind == 1 && cyc >= m_hs + 1 && cyc <= m_hs + XFER;
      exp_ot = act_tx ? int'(m_data[DW - 1 - (cyc - m_hs - 1) / BD]) : 0;
      exp_rdata = (!in_reset && m_kind == 2 && cyc >= m_hs + XFER + 1) ?
                  int'(m_data) : int'(m_rdata_prev);
      check_eq("pad_ts", int'(pad_ts), int'(!act_tx));
      check_eq("pad_otrue", int'(pad_otrue), exp_ot);
      check_eq("busy", int'(busy),
               int'(!in_reset && m_kind != 0 && cyc > m_hs && cyc < m_hs + SLOT));
      check_eq("rd_valid", int'(rd_valid),
               int'(!in_reset && m_kind == 2 && cyc == m_hs + XFER + 1));
      check_eq("rd_data", int'(rd_data), exp_rdata);
      check_eq("wr_ready", int'(wr_ready), int'(m_gnt_wr));
      check_eq("rd_ack", int'(rd_ack), int'(m_gnt_rd));
      check_eq("ready_ack_exclusive", int'(wr_ready & rd_ack), 0);

      if (!rst_n) begin
        run_len = 0;
      end else if (pad_ts == 1'b0) begin
        if (run_len == 0) run_start = cyc;
        if (run_len % BD == 0) word = {word[DW-2:0], pad_otrue};
        run_len++;
      end else if (run_len > 0) begin
        check_eq("wr_sb_pending", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          t = sb.pop_front();
          check_eq("wr_kind", int'(t.is_wr), 1);
          check_eq("wr_word", int'(word), int'(t.data));
          check_eq("wr_start", run_start, t.hs + 1);
          check_eq("wr_len", run_len, XFER);
          $display("WRITE data=%02h hs=%0d start=%0d len=%0d", word, t.hs, run_start, run_len);
        end
        run_len = 0;
      end

      if (rst_n && rd_valid) begin
        check_eq("rd_sb_pending", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          t = sb.pop_front();
          check_eq("rd_kind", int'(t.is_wr), 0);
          check_eq("rd_word", int'(rd_data), int'(t.data));
          check_eq("rd_latency", cyc, t.hs + XFER + 1);
          $display("READ  data=%02h hs=%0d valid_at=%0d", rd_data, t.hs, cyc);
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    #1 rst_n = 1'b0;
    do_reset(3);

    // single write and single read
    issue(1'b1, 1'b0, 8'hA5);
    idle(40);
    issue(1'b0, 1'b1, 8'h3C);
    idle(40);

    // read requested during the write's turnaround must wait for IDLE
    issue(1'b1, 1'b0, 8'h5A);
    while (cyc < m_hs + XFER + 1) idle(1);
    issue(1'b0, 1'b1, 8'hC3);
    idle(40);

    // both held after reset: strict alternation starting with write
    do_reset(1);
    repeat (5 * SLOT + 4)
      run_cycle(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
    idle(40);

    // reset in the middle of a drive, then a fresh write
    issue(1'b1, 1'b0, 8'hF0);
    while (cyc < m_hs + 12) idle(1);
    do_reset(1);
    issue(1'b1, 1'b0, 8'h81);
    idle(40);

    // randomized traffic with drops and occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        run_cycle($urandom_range(0, 2) == 0, 8'($urandom),
                  $urandom_range(0, 2) == 0, 8'($urandom), 1'b1);
      end
    end

    // drain and confirm nothing is left outstanding
    wr_valid = 1'b0;
    rd_req = 1'b0;
    idle(SLOT + 10);
    check_eq("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
